// File: rtl/rv32i_ctrl_fsm_pkg.sv
// rv32i_ctrl_fsm_pkg: shared encodings for the RV32I multi-cycle controller.
package rv32i_ctrl_fsm_pkg;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [4:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_sel_e;

    typedef enum logic [2:0] {IMM_I, IMM_S, IMM_B, IMM_U, IMM_J} imm_sel_e;

    typedef enum logic [1:0] {WB_MEM, WB_ALU, WB_PC4} wb_sel_e;

    typedef enum logic [2:0] {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP, S_HALT} state_e;

    typedef enum logic [3:0] {
        C_ILL, C_R, C_I, C_LOAD, C_STORE, C_LUI, C_AUIPC, C_JAL, C_JALR, C_BRANCH, C_SYS
    } iclass_e;

    // alt selects SUB/SRA; callers decide when funct7[5] is meaningful
    function automatic alu_sel_e alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'd0:    return alt ? ALU_SUB : ALU_ADD;
            3'd1:    return ALU_SLL;
            3'd2:    return ALU_SLT;
            3'd3:    return ALU_SLTU;
            3'd4:    return ALU_XOR;
            3'd5:    return alt ? ALU_SRA : ALU_SRL;
            3'd6:    return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction
endpackage

// File: rtl/rv32i_ctrl_fsm_if.sv
// rv32i_ctrl_fsm_if: instruction/flag inputs and datapath control outputs of the controller.
interface rv32i_ctrl_fsm_if #(parameter int CNT_W = 32);
    logic [31:0]      i_instr;
    logic             i_br_eq;
    logic             i_br_lt;
    logic             o_pc_wen;
    logic             o_ir_wen;
    logic             o_pc_sel;
    logic             o_reg_wen;
    logic             o_a_sel;
    logic             o_b_sel;
    logic [4:0]       o_alu_sel;
    logic [2:0]       o_imm_sel;
    logic             o_br_un;
    logic             o_mem_rw;
    logic [1:0]       o_wb_sel;
    logic             o_illegal;
    logic             o_halted;
    logic [CNT_W-1:0] o_retired;

    modport master (
        input  i_instr, i_br_eq, i_br_lt,
        output o_pc_wen, o_ir_wen, o_pc_sel, o_reg_wen, o_a_sel, o_b_sel, o_alu_sel,
               o_imm_sel, o_br_un, o_mem_rw, o_wb_sel, o_illegal, o_halted, o_retired
    );
    modport slave (
        output i_instr, i_br_eq, i_br_lt,
        input  o_pc_wen, o_ir_wen, o_pc_sel, o_reg_wen, o_a_sel, o_b_sel, o_alu_sel,
               o_imm_sel, o_br_un, o_mem_rw, o_wb_sel, o_illegal, o_halted, o_retired
    );
endinterface

// File: rtl/rv32i_ctrl_fsm_decode.sv
// rv32i_ctrl_fsm_decode: combinational instruction classifier and ALU/immediate setup.
module rv32i_ctrl_fsm_decode
    import rv32i_ctrl_fsm_pkg::*;
(
    input  logic [6:0] i_opcode,
    input  logic [2:0] i_funct3,
    input  logic       i_funct7_5,
    output iclass_e    o_class,
    output alu_sel_e   o_alu_sel,
    output imm_sel_e   o_imm_sel,
    output logic       o_br_un
);
    always_comb begin
        o_class = C_ILL;
        case (i_opcode)
            OP_R:      o_class = C_R;
            OP_I:      o_class = C_I;
            OP_LOAD:   o_class = C_LOAD;
            OP_STORE:  o_class = C_STORE;
            OP_LUI:    o_class = C_LUI;
            OP_AUIPC:  o_class = C_AUIPC;
            OP_JAL:    o_class = C_JAL;
            OP_JALR:   o_class = C_JALR;
            OP_BRANCH: o_class = C_BRANCH;
            OP_SYSTEM: o_class = C_SYS;
            default:   o_class = C_ILL;
        endcase
    end

    // immediate forms only honour funct7[5] for SRAI
    always_comb begin
        o_alu_sel = o_class == C_R   ? alu_from_f3(i_funct3, i_funct7_5) :
                    o_class == C_I   ? alu_from_f3(i_funct3, i_funct3 == 3'd5 && i_funct7_5) :
                    o_class == C_LUI ? ALU_PASSB : ALU_ADD;
        o_imm_sel = o_class == C_STORE                      ? IMM_S :
                    o_class == C_BRANCH                     ? IMM_B :
                    o_class inside {C_LUI, C_AUIPC}         ? IMM_U :
                    o_class == C_JAL                        ? IMM_J : IMM_I;
        o_br_un   = o_class == C_BRANCH && i_funct3[1];
    end
endmodule

// File: rtl/rv32i_ctrl_fsm.sv
// rv32i_ctrl_fsm: multi-cycle RV32I control unit stepping one instruction per 3-5 cycles.
module rv32i_ctrl_fsm
    import rv32i_ctrl_fsm_pkg::*;
#(
    parameter int CNT_W         = 32,
    parameter bit HALT_ON_ECALL = 1'b1
) (
    input logic            clk,
    input logic            rst,
    rv32i_ctrl_fsm_if.master bus
);
    state_e           r_state, w_next;
    logic [6:0]       r_opcode;
    logic [4:0]       r_rd;
    logic [2:0]       r_funct3;
    logic             r_funct7_5;
    logic [CNT_W-1:0] r_retired;
    iclass_e          w_class;
    alu_sel_e         w_alu;
    imm_sel_e         w_imm;
    logic             w_br_un, w_setup, w_jump, w_branch, w_taken, w_pc_wen;

    rv32i_ctrl_fsm_decode u_dec (
        .i_opcode(r_opcode), .i_funct3(r_funct3), .i_funct7_5(r_funct7_5),
        .o_class(w_class), .o_alu_sel(w_alu), .o_imm_sel(w_imm), .o_br_un(w_br_un)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_FETCH;
            r_opcode   <= '0;
            r_rd       <= '0;
            r_funct3   <= '0;
            r_funct7_5 <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_state <= w_next;
            if (bus.o_ir_wen) begin
                r_opcode   <= bus.i_instr[6:0];
                r_rd       <= bus.i_instr[11:7];
                r_funct3   <= bus.i_instr[14:12];
                r_funct7_5 <= bus.i_instr[30];
            end
            if (w_pc_wen) r_retired <= r_retired + CNT_W'(1);
        end
    end

    always_comb begin
        w_next   = r_state;
        w_setup  = r_state inside {S_EXEC, S_MEM, S_WB};
        w_jump   = w_class inside {C_JAL, C_JALR};
        w_branch = w_class == C_BRANCH;
        w_taken  = r_funct3[2] ? (bus.i_br_lt ^ r_funct3[0]) : (bus.i_br_eq ^ r_funct3[0]);
        case (r_state)
            S_FETCH:  w_next = S_DECODE;
            S_DECODE: w_next = w_class == C_ILL ? S_TRAP :
                               w_class == C_SYS ? (HALT_ON_ECALL ? S_HALT : S_FETCH) : S_EXEC;
            S_EXEC:   w_next = (w_jump || w_branch) ? S_FETCH :
                               w_class inside {C_LOAD, C_STORE} ? S_MEM : S_WB;
            S_MEM:    w_next = w_class == C_LOAD ? S_WB : S_FETCH;
            S_WB:     w_next = S_FETCH;
            default:  w_next = r_state;
        endcase
        // enables are masked by rst so a mid-instruction reset never commits a write
        w_pc_wen = !rst && ((r_state == S_DECODE && w_class == C_SYS && !HALT_ON_ECALL) ||
                            (r_state == S_EXEC && (w_jump || w_branch)) ||
                            (r_state == S_MEM && w_class == C_STORE) || r_state == S_WB);
    end

    assign bus.o_pc_wen  = w_pc_wen;
    assign bus.o_ir_wen  = r_state == S_FETCH;
    assign bus.o_pc_sel  = r_state == S_EXEC && (w_jump || (w_branch && w_taken));
    assign bus.o_reg_wen = !rst && r_rd != 5'd0 && ((r_state == S_EXEC && w_jump) || r_state == S_WB);
    assign bus.o_mem_rw  = !rst && r_state == S_MEM && w_class == C_STORE;
    assign bus.o_wb_sel  = (r_state == S_EXEC && w_jump)         ? WB_PC4 :
                           (r_state == S_WB && w_class != C_LOAD) ? WB_ALU : WB_MEM;
    assign bus.o_a_sel   = w_setup && w_class inside {C_AUIPC, C_JAL, C_BRANCH};
    assign bus.o_b_sel   = w_setup && w_class != C_R;
    assign bus.o_alu_sel = w_setup ? w_alu : ALU_ADD;
    assign bus.o_imm_sel = w_setup ? w_imm : IMM_I;
    assign bus.o_br_un   = w_setup && w_br_un;
    assign bus.o_illegal = r_state == S_TRAP;
    assign bus.o_halted  = r_state == S_HALT;
    assign bus.o_retired = r_retired;
endmodule

// File: tb/tb_rv32i_ctrl_fsm.sv
// tb_rv32i_ctrl_fsm: directed instruction stream with a retire-driven scoreboard,
// plus trap, halt and mid-instruction reset scenarios.
module tb_rv32i_ctrl_fsm;
    import rv32i_ctrl_fsm_pkg::*;

    typedef struct {
        int cyc; int pc_sel; int reg_wen; int wb; int alu; int imm;
        int asel; int bsel; int brun; int mw_cyc; int ret;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    exp_t q[$];
    int   checks = 0;
    int   errors = 0;
    int   exp_ret = 0;

    always #5 clk = ~clk;

    rv32i_ctrl_fsm_if #(.CNT_W(32)) bus();
    rv32i_ctrl_fsm #(.CNT_W(32), .HALT_ON_ECALL(1'b1)) dut (.clk(clk), .rst(rst), .bus(bus));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    function automatic exp_t mk(int c, int ps, int rw, int wb, int alu, int imm,
                                int a, int b, int bu, int mw);
        exp_t e;
        e.cyc = c; e.pc_sel = ps; e.reg_wen = rw; e.wb = wb; e.alu = alu; e.imm = imm;
        e.asel = a; e.bsel = b; e.brun = bu; e.mw_cyc = mw; e.ret = 0;
        return e;
    endfunction

    task automatic drive_fetch(input logic [31:0] ins, input logic eq, input logic lt);
        int n = 0;
        while (!bus.o_ir_wen && n < 30) begin
            @(negedge clk);
            n++;
        end
        if (!bus.o_ir_wen) chk("fetch_timeout", 0, 1);
        bus.i_instr = ins;
        bus.i_br_eq = eq;
        bus.i_br_lt = lt;
    endtask

    task automatic issue(input logic [31:0] ins, input logic eq, input logic lt, input exp_t e);
        drive_fetch(ins, eq, lt);
        e.ret = exp_ret;
        exp_ret++;
        q.push_back(e);
        @(negedge clk);
    endtask

    // monitor: cycle 1 is FETCH; every PCWEn pops one expected retirement
    initial begin
        int   cyc = 0;
        int   mw_cyc = 0;
        int   mw_cnt = 0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            cyc = bus.o_ir_wen ? 1 : cyc + 1;
            if (bus.o_ir_wen) begin
                mw_cyc = 0;
                mw_cnt = 0;
            end
            if (bus.o_mem_rw) begin
                mw_cyc = cyc;
                mw_cnt++;
            end
            if (bus.o_reg_wen && bus.o_mem_rw) chk("regwen_memrw_excl", 1, 0);
            if (bus.o_pc_wen) begin
                if (q.size() == 0) chk("unexpected_retire", 1, 0);
                else begin
                    e = q.pop_front();
                    chk("retire_cycle", cyc, e.cyc);
                    chk("pc_sel", bus.o_pc_sel, e.pc_sel);
                    chk("reg_wen", bus.o_reg_wen, e.reg_wen);
                    chk("wb_sel", bus.o_wb_sel, e.wb);
                    chk("alu_sel", bus.o_alu_sel, e.alu);
                    chk("imm_sel", bus.o_imm_sel, e.imm);
                    chk("a_sel", bus.o_a_sel, e.asel);
                    chk("b_sel", bus.o_b_sel, e.bsel);
                    chk("br_un", bus.o_br_un, e.brun);
                    chk("mem_rw_cycle", mw_cyc, e.mw_cyc);
                    chk("mem_rw_count", mw_cnt, e.mw_cyc != 0);
                    chk("retired", bus.o_retired, e.ret);
                end
            end
        end
    end

    initial begin
        bit seen;
        bit held;
        bus.i_instr = '0;
        bus.i_br_eq = 1'b0;
        bus.i_br_lt = 1'b0;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #2;
        chk("rst_ir_wen", bus.o_ir_wen, 1);
        chk("rst_enables", {bus.o_pc_wen, bus.o_reg_wen, bus.o_mem_rw, bus.o_pc_sel}, 0);
        chk("rst_setup", {bus.o_a_sel, bus.o_b_sel, bus.o_alu_sel, bus.o_imm_sel, bus.o_br_un}, 0);
        chk("rst_flags", {bus.o_wb_sel, bus.o_illegal, bus.o_halted}, 0);
        chk("rst_retired", bus.o_retired, 0);
        rst = 1'b0;
        //        instr          eq    lt       cyc ps rw wb alu imm a  b  bu mw
        issue(32'h0050_0093, 1'b0, 1'b0, mk(4, 0, 1, 1, 0,  0,  0, 1, 0, 0));
        issue(32'h0000_A103, 1'b0, 1'b0, mk(5, 0, 1, 0, 0,  0,  0, 1, 0, 0));
        issue(32'h0020_A223, 1'b0, 1'b0, mk(4, 0, 0, 0, 0,  1,  0, 1, 0, 4));
        issue(32'h0020_8463, 1'b1, 1'b0, mk(3, 1, 0, 0, 0,  2,  1, 1, 0, 0));
        issue(32'h0020_8463, 1'b0, 1'b0, mk(3, 0, 0, 0, 0,  2,  1, 1, 0, 0));
        issue(32'h0020_E463, 1'b0, 1'b1, mk(3, 1, 0, 0, 0,  2,  1, 1, 1, 0));
        issue(32'h0020_D463, 1'b0, 1'b1, mk(3, 0, 0, 0, 0,  2,  1, 1, 0, 0));
        issue(32'h0080_00EF, 1'b0, 1'b0, mk(3, 1, 1, 2, 0,  4,  1, 1, 0, 0));
        issue(32'h0020_8033, 1'b0, 1'b0, mk(4, 0, 0, 1, 0,  0,  0, 0, 0, 0));
        issue(32'h4020_81B3, 1'b0, 1'b0, mk(4, 0, 1, 1, 1,  0,  0, 0, 0, 0));
        issue(32'h4030_D213, 1'b0, 1'b0, mk(4, 0, 1, 1, 7,  0,  0, 1, 0, 0));
        issue(32'h1234_52B7, 1'b0, 1'b0, mk(4, 0, 1, 1, 10, 3,  0, 1, 0, 0));
        issue(32'h0000_1317, 1'b0, 1'b0, mk(4, 0, 1, 1, 0,  3,  1, 1, 0, 0));
        issue(32'h0001_00E7, 1'b0, 1'b0, mk(3, 1, 1, 2, 0,  0,  0, 1, 0, 0));
        drive_fetch(32'h0000_0000, 1'b0, 1'b0);
        #3;
        chk("queue_drained", q.size(), 0);
        chk("retired_total", bus.o_retired, exp_ret);
        repeat (2) @(negedge clk);
        #2;
        chk("illegal_set", bus.o_illegal, 1);
        seen = 1'b0;
        held = 1'b1;
        repeat (20) begin
            @(negedge clk);
            #2;
            seen |= bus.o_pc_wen | bus.o_reg_wen | bus.o_mem_rw | bus.o_ir_wen;
            held &= bus.o_illegal;
        end
        chk("trap_enables_quiet", seen, 0);
        chk("trap_sticky", held, 1);
        chk("trap_retired_frozen", bus.o_retired, exp_ret);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("trap_rst_clears", bus.o_illegal, 0);
        chk("trap_rst_fetch", bus.o_ir_wen, 1);
        chk("trap_rst_retired", bus.o_retired, 0);
        bus.i_instr = 32'h0000_0073;
        rst = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            #2;
            seen |= bus.o_pc_wen;
        end
        chk("ecall_halted", bus.o_halted, 1);
        chk("ecall_no_pc_wen", seen, 0);
        chk("ecall_retired", bus.o_retired, 0);
        rst = 1'b1;
        @(negedge clk);
        #2;
        chk("halt_rst_clears", bus.o_halted, 0);
        bus.i_instr = 32'h0020_A223;
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        seen = 1'b0;
        repeat (2) begin
            @(negedge clk);
            #2;
            seen |= bus.o_mem_rw;
        end
        chk("rst_in_exec_no_store", seen, 0);
        chk("rst_in_exec_fetch", bus.o_ir_wen, 1);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #2;
        chk("rst_in_mem_gated", {bus.o_mem_rw, bus.o_pc_wen}, 0);
        @(negedge clk);
        #2;
        chk("rst_in_mem_fetch", bus.o_ir_wen, 1);
        chk("rst_in_mem_retired", bus.o_retired, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
